// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter that picks one finished functional-unit result per cycle for the common data bus (CDB).
// Latency: the grant is combinational in the request cycle, and the CDB broadcast is registered one cycle later.
// Backpressure: a requester holds its payload until it sees its grant at a rising edge; a branch flush blocks every grant.
//
// Ports:
//   clk, rst (async active-low), br (mispredict flush)
//   req_valid/req_index/req_result/req_addr : packed per-requester request slices
//   grnt                                    : one-hot grant, combinational
//   cdb_valid/cdb_index/cdb_result/cdb_addr : registered broadcast
//   stat_sel/stat_grants/stat_conflicts     : saturating statistics, only when CDB_ARB_STATS_EN is defined
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      br,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_result,
  input  logic [NUM_REQ*DATA_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grnt,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_index,
  output logic [DATA_W-1:0]         cdb_result,
  output logic [DATA_W-1:0]         cdb_addr
`ifdef CDB_ARB_STATS_EN
  ,
  input  logic [2:0]                stat_sel,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_conflicts
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IW    = PTR_W + 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [IW-1:0]      idx;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic               grant_ok;
  logic [TAG_W-1:0]   win_index;
  logic [DATA_W-1:0]  win_result;
  logic [DATA_W-1:0]  win_addr;

  // Tag 0 means "no tag": such a request is masked and never takes the bus.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (req_index[i*TAG_W +: TAG_W] != '0);
    end
  end

  // Scan ptr, ptr+1, ... modulo NUM_REQ. The index is one bit wider so the
  // wrap works for requester counts that are not a power of two.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (!found && elig[idx[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = idx[PTR_W-1:0];
      end
    end
  end

  // A flush or a reset that is still asserted blocks the grant, so a requester never sees a transfer that cannot complete.
  assign grant_ok = found && !br && rst;

  always_comb begin
    grnt = '0;
    if (grant_ok) begin
      grnt[win_idx] = 1'b1;
    end
  end

  assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    win_index  = '0;
    win_result = '0;
    win_addr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grnt[i]) begin
        win_index  = req_index[i*TAG_W +: TAG_W];
        win_result = req_result[i*DATA_W +: DATA_W];
        win_addr   = req_addr[i*DATA_W +: DATA_W];
      end
    end
  end

  // The payload is cleared on every edge without a grant, so a stale tag never matches in the stations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      cdb_valid  <= 1'b0;
      cdb_index  <= '0;
      cdb_result <= '0;
      cdb_addr   <= '0;
    end else begin
      cdb_valid  <= grant_ok;
      cdb_index  <= win_index;
      cdb_result <= win_result;
      cdb_addr   <= win_addr;
      if (br) begin
        ptr <= '0;
      end else if (grant_ok) begin
        ptr <= ptr_nxt;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic        multi_elig;

  // x & (x-1) is non-zero when at least two bits of x are set.
  assign multi_elig = |(elig & (elig - NUM_REQ'(1)));

  // Only reset clears the counters. A flush leaves them unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_conflicts <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      if (multi_elig && stat_conflicts != 16'hFFFF) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grnt[i] && grant_cnt[i] != 16'hFFFF) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A value of stat_sel that matches no requester reads 0.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stat_sel == 3'(i)) begin
        stat_grants = grant_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose: directed self-checking bench for cdb_arbiter with the default parameters (4 requesters, 8-bit tags, 32-bit data).
// Timing: inputs are driven 1 ns after a rising edge, and the combinational grant and the registered outputs are sampled 1-2 ns after it.
// Coverage: reset, single grant, round robin, tag-0 masking, flush, back-to-back grants, async reset (plus the statistics when enabled).
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         br;
  logic [3:0]   req_valid;
  logic [31:0]  req_index;
  logic [127:0] req_result;
  logic [127:0] req_addr;
  logic [3:0]   grnt;
  logic         cdb_valid;
  logic [7:0]   cdb_index;
  logic [31:0]  cdb_result;
  logic [31:0]  cdb_addr;
`ifdef CDB_ARB_STATS_EN
  logic [2:0]   stat_sel;
  logic [15:0]  stat_grants;
  logic [15:0]  stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .br         (br),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_result (req_result),
    .req_addr   (req_addr),
    .grnt       (grnt),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result),
    .cdb_addr   (cdb_addr)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_sel       (stat_sel),
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] tag,
                         input logic [31:0] res, input logic [31:0] adr);
    req_valid[i]            = v;
    req_index[i*8 +: 8]     = tag;
    req_result[i*32 +: 32]  = res;
    req_addr[i*32 +: 32]    = adr;
  endtask

  task automatic clear_reqs();
    req_valid  = '0;
    req_index  = '0;
    req_result = '0;
    req_addr   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    br  = 1'b0;
    clear_reqs();
`ifdef CDB_ARB_STATS_EN
    stat_sel = 3'd0;
`endif
    set_req(0, 1'b1, 8'h01, 32'h1, 32'h0);
    #1;
    checks++;
    if (grnt !== 4'b0000) begin
      errors++; $display("FAIL reset_grnt got %b want 0000", grnt);
    end
    checks++;
    if (cdb_valid !== 1'b0 || cdb_index !== 8'h00 || cdb_result !== 32'h0 || cdb_addr !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got v=%b idx=%h res=%h addr=%h want all 0", cdb_valid, cdb_index, cdb_result, cdb_addr);
    end
    clear_reqs();
    #11 rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 8'h2C, 32'hDEADBEEF, 32'h0000_0100);
    #1;
    checks++;
    if (grnt !== 4'b0010) begin
      errors++; $display("FAIL single_grnt got %b want 0010", grnt);
    end
    tick();
    set_req(1, 1'b0, 8'h00, 32'h0, 32'h0);
    checks++;
    if (cdb_valid !== 1'b1 || cdb_index !== 8'h2C || cdb_result !== 32'hDEADBEEF || cdb_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL single_bcast got v=%b idx=%h res=%h addr=%h want 1 2c deadbeef 00000100", cdb_valid, cdb_index, cdb_result, cdb_addr);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_index !== 8'h00 || cdb_result !== 32'h0) begin
      errors++; $display("FAIL single_clear got v=%b idx=%h res=%h want 0 00 0", cdb_valid, cdb_index, cdb_result);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [7:0]  exp_t;
    // A reset pulse between edges returns ptr to 0 and clears the counters.
    rst = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 8'(i + 1), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
    end
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'(1 << (c % 4));
      exp_t = 8'((c % 4) + 1);
      #1;
      checks++;
      if (grnt !== exp_g) begin
        errors++; $display("FAIL rr_grnt cycle %0d got %b want %b", c, grnt, exp_g);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_index !== exp_t || cdb_result !== (32'hA000_0000 + 32'(c % 4))) begin
        errors++; $display("FAIL rr_bcast cycle %0d got v=%b idx=%h res=%h want 1 %h", c, cdb_valid, cdb_index, cdb_result, exp_t);
      end
    end
    clear_reqs();
`ifdef CDB_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      stat_sel = 3'(i);
      #1;
      checks++;
      if (stat_grants !== 16'd2) begin
        errors++; $display("FAIL rr_stat_grants req %0d got %0d want 2", i, stat_grants);
      end
    end
    stat_sel = 3'd5;
    #1;
    checks++;
    if (stat_grants !== 16'd0) begin
      errors++; $display("FAIL rr_stat_sel_oob got %0d want 0", stat_grants);
    end
    checks++;
    if (stat_conflicts !== 16'd8) begin
      errors++; $display("FAIL rr_stat_conflicts got %0d want 8", stat_conflicts);
    end
`endif
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL rr_idle got v=%b want 0", cdb_valid);
    end
  endtask

  task automatic test_tag_zero();
    // Granting requester 1 alone leaves ptr at 2.
    set_req(1, 1'b1, 8'h11, 32'h11, 32'h0);
    tick();
    set_req(1, 1'b0, 8'h00, 32'h0, 32'h0);
    set_req(2, 1'b1, 8'h00, 32'h2222, 32'h0);
    #1;
    checks++;
    if (grnt !== 4'b0000) begin
      errors++; $display("FAIL tag0_grnt got %b want 0000", grnt);
    end
    tick();
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_index !== 8'h00) begin
      errors++; $display("FAIL tag0_bcast got v=%b idx=%h want 0 00", cdb_valid, cdb_index);
    end
    // ptr must still be 2, so requester 2 beats requesters 3 and 0.
    set_req(0, 1'b1, 8'h20, 32'h20, 32'h0);
    set_req(2, 1'b1, 8'h22, 32'h22, 32'h0);
    set_req(3, 1'b1, 8'h23, 32'h23, 32'h0);
    #1;
    checks++;
    if (grnt !== 4'b0100) begin
      errors++; $display("FAIL tag0_ptr_hold got %b want 0100", grnt);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_flush();
    // Granting requester 1 leaves ptr at 2. Without the flush reset, requester 3 would win next.
    set_req(1, 1'b1, 8'h11, 32'h11, 32'h0);
    tick();
    set_req(1, 1'b0, 8'h00, 32'h0, 32'h0);
    set_req(0, 1'b1, 8'h30, 32'h30, 32'h0);
    set_req(3, 1'b1, 8'h33, 32'h33, 32'h0);
    br = 1'b1;
    #1;
    checks++;
    if (grnt !== 4'b0000) begin
      errors++; $display("FAIL flush_grnt got %b want 0000", grnt);
    end
    tick();
    br = 1'b0;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_index !== 8'h00 || cdb_result !== 32'h0) begin
      errors++; $display("FAIL flush_bcast got v=%b idx=%h res=%h want 0 00 0", cdb_valid, cdb_index, cdb_result);
    end
    #1;
    checks++;
    if (grnt !== 4'b0001) begin
      errors++; $display("FAIL flush_ptr got %b want 0001", grnt);
    end
    tick();
    set_req(0, 1'b0, 8'h00, 32'h0, 32'h0);
    checks++;
    if (cdb_index !== 8'h30) begin
      errors++; $display("FAIL flush_first got idx=%h want 30", cdb_index);
    end
    #1;
    checks++;
    if (grnt !== 4'b1000) begin
      errors++; $display("FAIL flush_second_grnt got %b want 1000", grnt);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    set_req(1, 1'b1, 8'h31, 32'h3131, 32'h0);
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_index !== 8'h31) begin
      errors++; $display("FAIL b2b_first got v=%b idx=%h want 1 31", cdb_valid, cdb_index);
    end
    set_req(1, 1'b1, 8'h32, 32'h3232, 32'h0);
    #1;
    checks++;
    if (grnt !== 4'b0010) begin
      errors++; $display("FAIL b2b_regrant got %b want 0010", grnt);
    end
    tick();
    clear_reqs();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_index !== 8'h32 || cdb_result !== 32'h3232) begin
      errors++; $display("FAIL b2b_second got v=%b idx=%h res=%h want 1 32 3232", cdb_valid, cdb_index, cdb_result);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got v=%b want 0", cdb_valid);
    end
  endtask

  task automatic test_async_reset();
    set_req(3, 1'b1, 8'h44, 32'h12345678, 32'h0000_8000);
    tick();
    set_req(3, 1'b0, 8'h00, 32'h0, 32'h0);
    checks++;
    if (cdb_valid !== 1'b1 || cdb_index !== 8'h44) begin
      errors++; $display("FAIL arst_pre got v=%b idx=%h want 1 44", cdb_valid, cdb_index);
    end
    set_req(0, 1'b1, 8'h50, 32'h50, 32'h0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || cdb_index !== 8'h00 || cdb_result !== 32'h0 || cdb_addr !== 32'h0) begin
      errors++; $display("FAIL arst_clear got v=%b idx=%h res=%h addr=%h want all 0", cdb_valid, cdb_index, cdb_result, cdb_addr);
    end
    checks++;
    if (grnt !== 4'b0000) begin
      errors++; $display("FAIL arst_grnt got %b want 0000", grnt);
    end
`ifdef CDB_ARB_STATS_EN
    stat_sel = 3'd3;
    #1;
    checks++;
    if (stat_grants !== 16'd0 || stat_conflicts !== 16'd0) begin
      errors++; $display("FAIL arst_stats got grants=%0d conflicts=%0d want 0 0", stat_grants, stat_conflicts);
    end
`endif
    clear_reqs();
    #1 rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tag_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) in the Tomasulo core. Functional units (ALU, LSU, branch unit, ...) post finished results with a tag. The arbiter grants at most one of them per cycle and registers the winner's payload as the single CDB broadcast seen by the reservation stations and the ROB. It sits between the functional units' `grnt`/`cdb_out_*` ports and the shared `cdb_in_*` nets.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TAG_W`, default 8: ROB tag width. Tag 0 means "no tag".
- `DATA_W`, default 32: result and address width.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `br`, in, 1: branch-mispredict flush.
- `req_valid`, in, `NUM_REQ`: requester i has a result pending.
- `req_index`, in, `NUM_REQ*TAG_W`: tag for requester i, at slice `[i*TAG_W +: TAG_W]`.
- `req_result`, in, `NUM_REQ*DATA_W`: result for requester i.
- `req_addr`, in, `NUM_REQ*DATA_W`: store address for requester i; 0 if unused.
- `grnt`, out, `NUM_REQ`: one-hot grant, combinational.
- `cdb_valid`, out, 1: broadcast valid.
- `cdb_index`, out, `TAG_W`: broadcast tag.
- `cdb_result`, out, `DATA_W`: broadcast result.
- `cdb_addr`, out, `DATA_W`: broadcast address.
- `stat_sel`, in, 3: selects which requester's counter appears on `stat_grants`. Present only with `CDB_ARB_STATS_EN`.
- `stat_grants`, out, 16: grant count for the requester picked by `stat_sel`. Present only with `CDB_ARB_STATS_EN`.
- `stat_conflicts`, out, 16: count of cycles with ≥2 eligible requesters. Present only with `CDB_ARB_STATS_EN`.

## Operation
- Eligible requester: `req_valid[i]=1` and `req_index[i]!=0`. A valid request with tag 0 is masked: never granted, never counted.
- Round-robin pointer `ptr` (`$clog2(NUM_REQ)` bits):
  - The winner is the first eligible requester scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - After a grant, `ptr` becomes winner+1, wrapping from `NUM_REQ-1` to 0.
  - With no grant, `ptr` holds.
- `grnt` is one-hot or zero. It is forced to zero while `br=1` or `rst=0`.
- Requester contract:
  - Hold `req_valid` and the payload stable until a rising edge at which `grnt[i]=1`.
  - At that edge the transfer completes.
  - The requester may present a new result in the following cycle.
- At a grant edge:
  - `cdb_index`, `cdb_result`, `cdb_addr` load the winner's payload.
  - `cdb_valid` goes to 1.
- At any edge without a grant, `cdb_valid` goes to 0. `cdb_index`, `cdb_result`, `cdb_addr` are cleared to 0 so stale tags never match in the stations.
- Flush (`br=1` at an edge):
  - No grant occurs.
  - `cdb_valid` and the payload registers clear.
  - `ptr` resets to 0.
  - Any pending requests are dropped by the requesters themselves, which also see `br`.
- Reset (asynchronous, `rst=0`): `ptr=0`, `cdb_valid=0`, `cdb_index=0`, `cdb_result=0`, `cdb_addr=0`, statistics counters 0. Reset mid-transfer discards the transfer.

## Timing
- Request to grant: 0 cycles (same cycle, combinational).
- Grant edge to `cdb_valid`: visible 1 cycle after the request is first seen. It lasts exactly one cycle per grant.
- Throughput: one broadcast per cycle. Back-to-back grants to different requesters produce a continuous `cdb_valid`.
- Fairness: with all `NUM_REQ` requesters continuously eligible, each one is granted exactly once every `NUM_REQ` cycles.
- `br` and `req_valid` high in the same cycle: `br` wins; no grant.

## Configuration
- `CDB_ARB_STATS_EN` defined:
  - One 16-bit saturating grant counter per requester. Each increments on every grant edge to that requester.
  - One 16-bit saturating conflict counter. It increments on every edge where ≥2 requesters were eligible.
  - Counters are cleared by reset only, not by `br`.
  - `stat_grants` shows the counter of requester `stat_sel`. If `stat_sel>=NUM_REQ`, it reads 0.
- `CDB_ARB_STATS_EN` undefined: the stat ports and counters do not exist; arbitration behaviour is identical.

## Test plan
- Single requester: after reset, `req_valid=4'b0010`, requester 1 tag 8'h2C, result 32'hDEADBEEF.
  - Required: `grnt=4'b0010` in the same cycle.
  - Next cycle: `cdb_valid=1`, `cdb_index=8'h2C`, `cdb_result=32'hDEADBEEF`.
  - The cycle after: `cdb_valid=0`, `cdb_index=0`.
- All four requesters held valid for 8 cycles, tags 1..4.
  - Required grant sequence: 0,1,2,3,0,1,2,3.
  - `cdb_valid` high for 8 consecutive cycles.
  - With `CDB_ARB_STATS_EN`: each grant counter = 2, conflict counter = 8.
- Requester 2 valid with tag 0, alone.
  - Required: `grnt=0`, `cdb_valid` stays 0, `ptr` unchanged.
- Requesters 0 and 3 valid, `br=1` in the same cycle.
  - Required: `grnt=0`, `cdb_valid=0` next cycle, `ptr=0`.
  - With `br` then low and both still valid: requester 0 is granted first.
- Assert `rst=0` asynchronously between edges while `cdb_valid=1`.
  - Required: `cdb_valid` and all payload outputs drop to 0 immediately, without waiting for a clock.
  - With `CDB_ARB_STATS_EN`: stats read 0.
